count_sched: RTL and testbench

Scheduler that shares one up-counter (active-high synchronous reset, load, preload value, free-running count output) between two requesters. Each requester asks for a timed interval: the counter is preloaded with a start value and runs until it reaches a stop value. The block arbitrates, issues the load, watches the count, signals completion and parks the counter between jobs. It sits between the requesters and the counter instance.

---
 rtl/count_sched_if.sv | 30 +++
 rtl/count_sched.sv | 94 +++++++++
 tb/tb_count_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sched_if.sv
// count_sched_if: requester and counter-side bundle for count_sched.
// slave = scheduler side, master = requesters plus counter side.
interface count_sched_if #(
  parameter int WIDTH = 8
) ();
  logic [1:0]         req;
  logic [2*WIDTH-1:0] start_v;
  logic [2*WIDTH-1:0] stop_v;
  logic [1:0]         ack;
  logic [1:0]         done;
  logic               abort;
  logic               busy;
  logic               owner;
  logic               cnt_rst;
  logic               cnt_ld;
  logic [WIDTH-1:0]   cnt_v;
  logic [WIDTH-1:0]   cnt_count;

  modport master (
    output req, start_v, stop_v, abort, cnt_count,
    input  ack, done, busy, owner,
    input  cnt_rst, cnt_ld, cnt_v
  );

  modport slave (
    input  req, start_v, stop_v, abort, cnt_count,
    output ack, done, busy, owner,
    output cnt_rst, cnt_ld, cnt_v
  );
endinterface

// File: rtl/count_sched.sv
// count_sched: shares one up-counter between two timed-interval requesters.
// Ports: clk, rst (async, active low), bus (count_sched_if.slave):
//   req/start_v/stop_v/abort in, ack/done/busy/owner out,
//   cnt_rst/cnt_ld/cnt_v drive the counter, cnt_count reads it back.
// Define COUNT_SCHED_RR_EN for round-robin; default is fixed priority.
module count_sched #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  count_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             g;
  logic             take;
  logic [1:0]       ack_q;
  logic             owner_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] stop_q;

  assign take = (state_q == IDLE) && (|bus.req);

`ifdef COUNT_SCHED_RR_EN
  logic ptr_q;

  // A lone requester always wins; the pointer breaks ties.
  always_comb begin
    g = bus.req[1];
    if (bus.req == 2'b11) g = ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else if (take) ptr_q <= ~g;
  end
`else
  assign g = ~bus.req[0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|bus.req) state_d = LOAD;
      LOAD: state_d = bus.abort ? IDLE : RUN;
      RUN: begin
        // abort wins over a same-cycle match
        if (bus.abort) state_d = IDLE;
        else if (bus.cnt_count == stop_q)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 2'b00;
      owner_q <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= 2'b00;
      if (take) begin
        ack_q   <= {g, ~g};
        owner_q <= g;
        start_q <= g ? bus.start_v[WIDTH +: WIDTH]
                     : bus.start_v[0 +: WIDTH];
        stop_q  <= g ? bus.stop_v[WIDTH +: WIDTH]
                     : bus.stop_v[0 +: WIDTH];
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = {owner_q, ~owner_q}
                     & {2{state_q == DONE}};
  assign bus.busy    = (state_q != IDLE);
  assign bus.owner   = owner_q;
  assign bus.cnt_rst = (state_q == IDLE)
                    || (state_q == DONE);
  assign bus.cnt_ld  = (state_q == LOAD);
  assign bus.cnt_v   = start_q;
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: random and directed checks of count_sched
// against a job-timeline model driving a behavioural counter.
module tb_count_sched;
  localparam int W = 8;
`ifdef COUNT_SCHED_RR_EN
  localparam logic [1:0] SECOND = 2'b10;
`else
  localparam logic [1:0] SECOND = 2'b01;
`endif

  logic clk;
  logic rst;
  logic [W-1:0] cnt;

  count_sched_if #(.WIDTH(W)) bus ();

  count_sched #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.cnt_count = cnt;

  always @(posedge clk) begin
    if (bus.cnt_rst) cnt <= '0;
    else if (bus.cnt_ld) cnt <= bus.cnt_v;
    else cnt <= cnt + 1'b1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: mk = cycles since ack of the live job, -1 when idle.
  // A job is ack/load at mk 0, runs ml cycles, then done at ml+1.
  int mk = -1;
  int ml = 0;
  logic mo = 1'b0;
  logic mptr = 1'b0;
  logic [W-1:0] ms = '0;
  logic [1:0] hreq = 2'b00;

  int ackc[$];
  logic [1:0] ackv[$];
  int donec[$];
  logic [1:0] donev[$];

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string n, input int a,
                       input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               n, cyc, a, e);
    end
  endtask

  task automatic model_adv(input logic [1:0] r,
                           input logic ab);
    logic g;
    logic [W-1:0] s;
    logic [W-1:0] e;
    logic [W-1:0] d;
    if (mk < 0) begin
      if (r != 2'b00) begin
        if (r == 2'b01) g = 1'b0;
        else if (r == 2'b10) g = 1'b1;
        else begin
`ifdef COUNT_SCHED_RR_EN
          g = mptr;
`else
          g = 1'b0;
`endif
        end
        mptr = ~g;
        s = g ? bus.start_v[W +: W] : bus.start_v[0 +: W];
        e = g ? bus.stop_v[W +: W] : bus.stop_v[0 +: W];
        d = e - s;
        mo = g;
        ms = s;
        ml = int'(d) + 1;
        mk = 0;
      end
    end else if (ab && mk <= ml) mk = -1;
    else if (mk == ml + 1) mk = -1;
    else mk++;
  endtask

  always @(negedge clk) begin
    logic [1:0] ea;
    logic [1:0] ed;
    ea = (mk == 0) ? oh(mo) : 2'b00;
    ed = (mk == ml + 1) ? oh(mo) : 2'b00;
    check("ack", int'(bus.ack), int'(ea));
    check("done", int'(bus.done), int'(ed));
    check("busy", int'(bus.busy), int'(mk >= 0));
    check("cnt_rst", int'(bus.cnt_rst),
          int'(mk < 0 || mk == ml + 1));
    check("cnt_ld", int'(bus.cnt_ld), int'(mk == 0));
    check("owner", int'(bus.owner), int'(mo));
    if (mk == 0) check("cnt_v", int'(bus.cnt_v), int'(ms));
  end

  task automatic tick(input logic ab);
    bus.req = hreq;
    bus.abort = ab;
    @(posedge clk);
    model_adv(bus.req, bus.abort);
    #1;
    cyc++;
    if (bus.ack != 2'b00) begin
      ackc.push_back(cyc);
      ackv.push_back(bus.ack);
    end
    if (bus.done != 2'b00) begin
      donec.push_back(cyc);
      donev.push_back(bus.done);
    end
    hreq = hreq & ~bus.ack;
  endtask

  task automatic wait_ack(input int bound);
    int n0;
    int n;
    n0 = ackc.size();
    n = 0;
    while (ackc.size() == n0 && n < bound) begin
      tick(1'b0);
      n++;
    end
    check("ack_wait", int'(ackc.size() > n0), 1);
  endtask

  task automatic wait_done(input int bound);
    int n0;
    int n;
    n0 = donec.size();
    n = 0;
    while (donec.size() == n0 && n < bound) begin
      tick(1'b0);
      n++;
    end
    check("done_wait", int'(donec.size() > n0), 1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((mk >= 0 || bus.busy) && n < bound) begin
      tick(1'b0);
      n++;
    end
    check("drain", int'(bus.busy), 0);
  endtask

  initial begin
    int n;
    int a;
    logic ab;
    logic [W-1:0] st;
    logic [W-1:0] len;

    rst = 1'b0;
    hreq = 2'b11;
    bus.req = 2'b11;
    bus.abort = 1'b0;
    bus.start_v = {8'd3, 8'd3};
    bus.stop_v = {8'd3, 8'd3};
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", int'(bus.ack), 0);
    check("rst_cnt_rst", int'(bus.cnt_rst), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cnt_v", int'(bus.cnt_v), 0);
    check("rst_owner", int'(bus.owner), 0);
    @(negedge clk);
    rst = 1'b1;

    // contention with both held, start = stop = 3
    n = 0;
    while (ackc.size() < 3 && n < 60) begin
      hreq = 2'b11;
      tick(1'b0);
      n++;
    end
    hreq = 2'b00;
    if (ackc.size() == 3 && donec.size() > 0) begin
      check("first_ack_cyc", ackc[0], 1);
      check("cont_ack0", int'(ackv[0]), 1);
      check("cont_ack1", int'(ackv[1]), int'(SECOND));
      check("cont_ack2", int'(ackv[2]), 1);
      check("ss_len", donec[0] - ackc[0], 2);
      check("spacing", ackc[1] - ackc[0], 4);
    end else begin
      check("cont_count", ackc.size(), 3);
    end
    drain(20);

    // basic job: requester 0, 5 -> 9
    bus.start_v[0 +: W] = 8'd5;
    bus.stop_v[0 +: W] = 8'd9;
    hreq = 2'b01;
    wait_ack(10);
    a = ackc[$];
    wait_done(40);
    check("basic_len", donec[$] - a, 6);
    check("basic_done", int'(donev[$]), 1);
    tick(1'b0);
    check("basic_rst", int'(bus.cnt_rst), 1);
    drain(20);

    // wrap: requester 1, FE -> 01
    bus.start_v[W +: W] = 8'hFE;
    bus.stop_v[W +: W] = 8'h01;
    hreq = 2'b10;
    wait_ack(10);
    a = ackc[$];
    wait_done(40);
    check("wrap_len", donec[$] - a, 5);
    check("wrap_done", int'(donev[$]), 2);
    drain(20);

    // abort at count 7 of 5 -> 20 with requester 1 pending
    bus.start_v[0 +: W] = 8'd5;
    bus.stop_v[0 +: W] = 8'd20;
    hreq = 2'b01;
    wait_ack(10);
    bus.start_v[W +: W] = 8'd2;
    bus.stop_v[W +: W] = 8'd2;
    hreq[1] = 1'b1;
    n = 0;
    while (cnt != 8'd7 && n < 30) begin
      tick(1'b0);
      n++;
    end
    check("abort_at7", int'(cnt), 7);
    tick(1'b1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_cnt_rst", int'(bus.cnt_rst), 1);
    tick(1'b0);
    check("abort_next_ack", int'(bus.ack), 2);
    drain(20);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hreq[k] && $urandom_range(0, 4) == 0) begin
          st = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0)
            len = 8'($urandom_range(0, 255));
          else len = 8'($urandom_range(0, 9));
          bus.start_v[k*W +: W] = st;
          bus.stop_v[k*W +: W] = st + len;
          hreq[k] = 1'b1;
        end else if (hreq[k] && $urandom_range(0, 49) == 0) begin
          hreq[k] = 1'b0;
        end
      end
      ab = (mk >= 0) && ($urandom_range(0, 24) == 0);
      tick(ab);
    end
    hreq = 2'b00;
    drain(300);

    // reset in the middle of a job
    bus.start_v[0 +: W] = 8'd0;
    bus.stop_v[0 +: W] = 8'd100;
    hreq = 2'b01;
    wait_ack(10);
    repeat (3) tick(1'b0);
    rst = 1'b0;
    mk = -1;
    mo = 1'b0;
    mptr = 1'b0;
    hreq = 2'b00;
    bus.req = 2'b00;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_cnt_rst", int'(bus.cnt_rst), 1);
    check("mid_rst_owner", int'(bus.owner), 0);
    check("mid_rst_ld", int'(bus.cnt_ld), 0);
    @(negedge clk);
    rst = 1'b1;
    bus.start_v = {8'd1, 8'd1};
    bus.stop_v = {8'd1, 8'd1};
    hreq = 2'b11;
    wait_ack(5);
    check("post_rst_ack", int'(ackv[$]), 1);
    hreq = 2'b00;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
